// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between fetch/execute and the branch resolve queue.
// The queue takes the slave view; the pipeline driving it takes the master view.
// Carries the push and resolve requests, the flush, and the BHT update/redirect results.
interface branch_resolve_queue_if #(
    parameter int PTR_W       = 2,
    parameter int INDEX_WIDTH = 6,
    parameter int ADDR_WIDTH  = 64
);
    logic                   i_pred_valid;
    logic                   i_pred_taken;
    logic [INDEX_WIDTH-1:0] i_pred_index;
    logic [ADDR_WIDTH-1:0]  i_pred_pc;
    logic                   o_pred_ready;
    logic                   i_res_valid;
    logic                   i_res_taken;
    logic [ADDR_WIDTH-1:0]  i_res_target;
    logic                   o_res_ready;
    logic                   i_flush;
    logic                   o_bht_update;
    logic                   o_branch_taken;
    logic [INDEX_WIDTH-1:0] o_set_index;
    logic                   o_mispredict;
    logic [ADDR_WIDTH-1:0]  o_redirect_pc;
    logic [PTR_W:0]         o_count;

    modport slave (
        input  i_pred_valid, i_pred_taken, i_pred_index, i_pred_pc,
        input  i_res_valid, i_res_taken, i_res_target, i_flush,
        output o_pred_ready, o_res_ready, o_bht_update, o_branch_taken,
        output o_set_index, o_mispredict, o_redirect_pc, o_count
    );

    modport master (
        output i_pred_valid, i_pred_taken, i_pred_index, i_pred_pc,
        output i_res_valid, i_res_taken, i_res_target, i_flush,
        input  o_pred_ready, o_res_ready, o_bht_update, o_branch_taken,
        input  o_set_index, o_mispredict, o_redirect_pc, o_count
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-time branch predictions, retired by execute resolutions.
// Latency: BHT update / mispredict / redirect registered, one cycle after the resolve edge.
// Backpressure: o_pred_ready low when full, o_res_ready low when empty; unready requests are ignored.
// Ports: i_clk, i_rst_n (sync, active low); bus (slave) carries push, resolve, flush,
//        BHT update (o_bht_update/o_branch_taken/o_set_index), mispredict/redirect and occupancy.
module branch_resolve_queue #(
    parameter int DEPTH       = 4,
    parameter int PTR_W       = 2,
    parameter int INDEX_WIDTH = 6,
    parameter int ADDR_WIDTH  = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    branch_resolve_queue_if.slave bus
);
    typedef struct packed {
        logic                   taken;
        logic [INDEX_WIDTH-1:0] index;
        logic [ADDR_WIDTH-1:0]  pc;
    } entry_t;

    localparam logic [PTR_W:0]      FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    entry_t                 mem_q [DEPTH];
    entry_t                 mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic                   bht_update_q, bht_update_d;
    logic                   branch_taken_q, branch_taken_d;
    logic [INDEX_WIDTH-1:0] set_index_q, set_index_d;
    logic                   mispredict_q, mispredict_d;
    logic [ADDR_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;

    logic   pred_ready;
    logic   res_ready;
    logic   push_fire;
    logic   res_fire;
    logic   mispred;
    entry_t head;

    assign pred_ready = (count_q < FULL_CNT);
    assign res_ready  = (count_q != '0);
    assign push_fire  = bus.i_pred_valid & pred_ready;
    assign res_fire   = bus.i_res_valid & res_ready;
    assign head       = mem_q[rd_ptr_q];
    assign mispred    = res_fire & (head.taken != bus.i_res_taken);

    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        bht_update_d   = 1'b0;
        mispredict_d   = 1'b0;
        branch_taken_d = branch_taken_q;
        set_index_d    = set_index_q;
        redirect_pc_d  = redirect_pc_q;

        if (bus.i_flush) begin
            // External flush discards everything, including this cycle's requests.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (res_fire) begin
                bht_update_d   = 1'b1;
                branch_taken_d = bus.i_res_taken;
                set_index_d    = head.index;
                mispredict_d   = mispred;
                if (mispred) begin
                    redirect_pc_d = bus.i_res_taken ? bus.i_res_target : head.pc + PC_STEP;
                end
            end
            if (mispred) begin
                // Everything younger, and any same-cycle push, is wrong-path.
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push_fire) begin
                    mem_d[wr_ptr_q] = '{taken: bus.i_pred_taken,
                                        index: bus.i_pred_index,
                                        pc:    bus.i_pred_pc};
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (res_fire) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                count_d = count_q + (PTR_W+1)'(push_fire) - (PTR_W+1)'(res_fire);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            bht_update_q   <= 1'b0;
            branch_taken_q <= 1'b0;
            set_index_q    <= '0;
            mispredict_q   <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            bht_update_q   <= bht_update_d;
            branch_taken_q <= branch_taken_d;
            set_index_q    <= set_index_d;
            mispredict_q   <= mispredict_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    // Entry payload needs no reset; occupancy tracking makes stale slots unreachable.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign bus.o_pred_ready   = pred_ready;
    assign bus.o_res_ready    = res_ready;
    assign bus.o_bht_update   = bht_update_q;
    assign bus.o_branch_taken = branch_taken_q;
    assign bus.o_set_index    = set_index_q;
    assign bus.o_mispredict   = mispredict_q;
    assign bus.o_redirect_pc  = redirect_pc_q;
    assign bus.o_count        = count_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, then random traffic vs a queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench honours nothing; it drives requests freely and expects unready ones ignored.
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int IW    = 6;
    localparam int AW    = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.PTR_W(PTR_W), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

    branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic          rst_n, pv, pt;
        logic [IW-1:0] pidx;
        logic [AW-1:0] ppc;
        logic          rv, rt;
        logic [AW-1:0] rtgt;
        logic          fl;
        int            cnt;
        logic          upd, mis;
        logic [IW-1:0] idx;
        logic          bt;
        logic [AW-1:0] rpc;
    } vec_t;

    typedef struct {
        logic          taken;
        logic [IW-1:0] idx;
        logic [AW-1:0] pc;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    int   checks   = 0;
    int   failures = 0;

    logic          m_upd, m_mis, m_bt;
    logic [IW-1:0] m_idx;
    logic [AW-1:0] m_rpc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic pv, input logic pt, input int pidx, input logic [AW-1:0] ppc,
                        input logic rv, input logic rt, input logic [AW-1:0] rtgt, input logic fl,
                        input int cnt, input logic upd, input logic mis, input int idx, input logic bt,
                        input logic [AW-1:0] rpc);
        vec_t v;
        v.rst_n = r; v.pv = pv; v.pt = pt; v.pidx = IW'(pidx); v.ppc = ppc;
        v.rv = rv; v.rt = rt; v.rtgt = rtgt; v.fl = fl;
        v.cnt = cnt; v.upd = upd; v.mis = mis; v.idx = IW'(idx); v.bt = bt; v.rpc = rpc;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic pv, input logic pt, input logic [IW-1:0] pidx,
                         input logic [AW-1:0] ppc, input logic rv, input logic rt,
                         input logic [AW-1:0] rtgt, input logic fl);
        rst_n            = r;
        bus.i_pred_valid = pv;
        bus.i_pred_taken = pt;
        bus.i_pred_index = pidx;
        bus.i_pred_pc    = ppc;
        bus.i_res_valid  = rv;
        bus.i_res_taken  = rt;
        bus.i_res_target = rtgt;
        bus.i_flush      = fl;
    endtask

    // Reference: a plain queue of predictions, with resolve/flush rules applied per edge.
    task automatic model_step(input logic r, input logic pv, input logic pt, input logic [IW-1:0] pidx,
                              input logic [AW-1:0] ppc, input logic rv, input logic rt,
                              input logic [AW-1:0] rtgt, input logic fl);
        ent_t e;
        int   pre;
        logic bad;
        if (!r) begin
            mq.delete();
            m_upd = 0; m_mis = 0; m_bt = 0; m_idx = '0; m_rpc = '0;
        end else begin
            m_upd = 0;
            m_mis = 0;
            if (fl) begin
                mq.delete();
            end else begin
                pre = mq.size();
                bad = 0;
                if (rv && pre != 0) begin
                    e     = mq.pop_front();
                    m_upd = 1;
                    m_bt  = rt;
                    m_idx = e.idx;
                    bad   = (e.taken != rt);
                    m_mis = bad;
                    if (bad) m_rpc = rt ? rtgt : e.pc + 64'd4;
                end
                if (bad) begin
                    mq.delete();
                end else if (pv && pre < DEPTH) begin
                    e.taken = pt; e.idx = pidx; e.pc = ppc;
                    mq.push_back(e);
                end
            end
        end
    endtask

    initial begin
        drive(1'b0, 0, 0, '0, '0, 0, 0, '0, 0);

        // Reset and fill to full; 5th push ignored.
        addv(0, 0,0,0,0,        0,0,0,      0, 0, 0,0,0,0,0);
        for (int k = 0; k < 4; k++)
            addv(1, 1,1,k+1,64'h100+64'(4*k), 0,0,0, 0, k+1, 0,0,0,0,0);
        addv(1, 1,1,5,64'h110,  0,0,0,      0, 4, 0,0,0,0,0);
        // Correct resolve, then mispredict (pred taken, actual not-taken).
        addv(1, 0,0,0,0,        1,1,64'h500,0, 3, 1,0,1,1,0);
        addv(1, 0,0,0,0,        1,0,64'h600,0, 0, 1,1,2,0,64'h108);
        // Pred not-taken, actual taken; concurrent push dropped.
        addv(1, 1,0,7,64'h200,  0,0,0,      0, 1, 0,0,0,0,64'h108);
        addv(1, 1,1,8,64'h204,  1,1,64'h400,0, 0, 1,1,7,1,64'h400);
        // Fill, then resolve + blocked push.
        for (int k = 0; k < 4; k++)
            addv(1, 1,1,9+k,64'h300+64'(4*k), 0,0,0, 0, k+1, 0,0,0,0,64'h400);
        addv(1, 1,1,30,64'h3F0, 1,1,64'h700,0, 3, 1,0,9,1,64'h400);
        // Eight push+resolve pairs at count 3 exercise pointer wrap.
        for (int k = 0; k < 8; k++)
            addv(1, 1,1,13+k,64'h400+64'(4*k), 1,1,64'h800,0, 3, 1,0,10+k,1,64'h400);
        addv(1, 0,0,0,0,        1,1,64'h900,0, 2, 1,0,18,1,64'h400);
        // External flush with a resolve pending: no update.
        addv(1, 1,1,40,64'h50,  1,0,64'h900,1, 0, 0,0,0,0,64'h400);
        addv(1, 1,1,21,64'h60,  0,0,0,      0, 1, 0,0,0,0,64'h400);
        addv(1, 1,0,22,64'h64,  0,0,0,      0, 2, 0,0,0,0,64'h400);
        // Mid-stream reset beats push and resolve.
        addv(0, 1,1,23,64'h68,  1,0,64'hA0,0, 0, 0,0,0,0,0);
        addv(1, 1,1,3,64'h10,   0,0,0,      0, 1, 0,0,0,0,0);
        addv(1, 0,0,0,0,        1,1,64'h20, 0, 0, 1,0,3,1,0);
        // Resolve while empty: ignored.
        addv(1, 0,0,0,0,        1,0,64'h30, 0, 0, 0,0,0,0,0);
        // pc+4 wraps modulo 2^64.
        addv(1, 1,1,63,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0, 0, 1, 0,0,0,0,0);
        addv(1, 0,0,0,0,        1,0,64'h40, 0, 0, 1,1,63,0,64'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            drive(v.rst_n, v.pv, v.pt, v.pidx, v.ppc, v.rv, v.rt, v.rtgt, v.fl);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_count", i), 64'(bus.o_count), 64'(v.cnt));
            chk($sformatf("row%0d_pred_ready", i), 64'(bus.o_pred_ready), 64'(v.cnt < DEPTH));
            chk($sformatf("row%0d_res_ready", i), 64'(bus.o_res_ready), 64'(v.cnt != 0));
            chk($sformatf("row%0d_bht_update", i), 64'(bus.o_bht_update), 64'(v.upd));
            chk($sformatf("row%0d_mispredict", i), 64'(bus.o_mispredict), 64'(v.mis));
            if (v.upd || !v.rst_n) begin
                chk($sformatf("row%0d_set_index", i), 64'(bus.o_set_index), 64'(v.idx));
                chk($sformatf("row%0d_branch_taken", i), 64'(bus.o_branch_taken), 64'(v.bt));
            end
            if (v.mis || !v.rst_n)
                chk($sformatf("row%0d_redirect_pc", i), bus.o_redirect_pc, v.rpc);
        end

        // Random traffic against the queue model, starting from reset.
        for (int c = 0; c < 600; c++) begin
            logic          r, pv, pt, rv, rt, fl;
            logic [IW-1:0] pidx;
            logic [AW-1:0] ppc, rtgt;
            r    = (c == 0) ? 1'b0 : ($urandom_range(99) != 0);
            pv   = ($urandom_range(99) < 65);
            pt   = $urandom_range(1);
            pidx = IW'($urandom);
            ppc  = {$urandom, $urandom};
            rv   = ($urandom_range(99) < 50);
            rt   = ($urandom_range(99) < 70) ? pt : $urandom_range(1);
            rtgt = {$urandom, $urandom};
            fl   = ($urandom_range(99) < 3);
            drive(r, pv, pt, pidx, ppc, rv, rt, rtgt, fl);
            model_step(r, pv, pt, pidx, ppc, rv, rt, rtgt, fl);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_count", c), 64'(bus.o_count), 64'(mq.size()));
            chk($sformatf("rnd%0d_pred_ready", c), 64'(bus.o_pred_ready), 64'(mq.size() < DEPTH));
            chk($sformatf("rnd%0d_res_ready", c), 64'(bus.o_res_ready), 64'(mq.size() != 0));
            chk($sformatf("rnd%0d_bht_update", c), 64'(bus.o_bht_update), 64'(m_upd));
            chk($sformatf("rnd%0d_mispredict", c), 64'(bus.o_mispredict), 64'(m_mis));
            if (m_upd) begin
                chk($sformatf("rnd%0d_set_index", c), 64'(bus.o_set_index), 64'(m_idx));
                chk($sformatf("rnd%0d_branch_taken", c), 64'(bus.o_branch_taken), 64'(m_bt));
            end
            chk($sformatf("rnd%0d_redirect_pc", c), bus.o_redirect_pc, m_rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
In-order queue that tracks branch predictions made at fetch until the execute stage resolves them. On each resolution it issues the BHT update (index, actual direction). When the predicted and actual directions disagree, it raises a one-cycle mispredict with the redirect PC and flushes all younger in-flight predictions. It is the update-side companion of the 2-bit BHT: its o_bht_update, o_branch_taken and o_set_index outputs drive the BHT's update inputs directly.

Parameters:
DEPTH, 4, number of in-flight branch entries (power of two, >= 2)
PTR_W, 2, log2(DEPTH)
INDEX_WIDTH, 6, BHT set-index width
ADDR_WIDTH, 64, PC width

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  synchronous active-low reset
i_pred_valid  input  1  fetch pushes a predicted branch
i_pred_taken  input  1  predicted direction (BHT bit[1])
i_pred_index  input  INDEX_WIDTH  BHT set index used for the prediction
i_pred_pc  input  ADDR_WIDTH  branch PC
o_pred_ready  output  1  queue can accept a push (count < DEPTH)
i_res_valid  input  1  execute resolves the oldest branch
i_res_taken  input  1  actual direction
i_res_target  input  ADDR_WIDTH  computed taken target
o_res_ready  output  1  queue holds at least one entry (count != 0)
i_flush  input  1  external pipeline flush (trap/exception)
o_bht_update  output  1  BHT update strobe
o_branch_taken  output  1  actual direction for the BHT
o_set_index  output  INDEX_WIDTH  BHT index to update
o_mispredict  output  1  one-cycle mispredict pulse
o_redirect_pc  output  ADDR_WIDTH  correct fetch PC, valid with o_mispredict
o_count  output  PTR_W+1  current occupancy

Behaviour:
- Reset (i_rst_n=0 at an edge): wr_ptr=rd_ptr=0, count=0, and all registered outputs are 0 (o_bht_update, o_branch_taken, o_set_index, o_mispredict, o_redirect_pc).
  - Entry contents are don't-care after reset.
  - Reset takes precedence over every other input in the same cycle.
- Storage: circular buffer of DEPTH entries {taken, index, pc}. The pointers wrap modulo DEPTH; count is tracked separately, range 0..DEPTH.
- o_pred_ready = (count < DEPTH). o_res_ready = (count != 0). Both are combinational from count only.
- Push fires when i_pred_valid & o_pred_ready. It writes the entry at wr_ptr and increments wr_ptr. A push while full is ignored, with no state change.
- Resolve fires when i_res_valid & o_res_ready. It reads the entry at rd_ptr and increments rd_ptr. A resolve while empty is ignored; no update is issued.
- Resolve outputs, registered, appearing on the cycle after the resolve edge:
  - o_bht_update=1, o_branch_taken=i_res_taken, o_set_index=entry.index.
  - o_mispredict=1 iff entry.taken != i_res_taken.
  - o_redirect_pc = i_res_target if i_res_taken, else entry.pc + 4 (modulo 2^ADDR_WIDTH).
  - All strobes are 1 for exactly one cycle, then 0 unless another resolve fires. o_redirect_pc holds its last value when o_mispredict=0.
- Mispredict flush: on a mispredicting resolve, the next state is wr_ptr=rd_ptr=0 and count=0. A push in the same cycle is dropped because it is wrong-path.
- Simultaneous push and non-mispredicting resolve: both take effect and count is unchanged. This is legal when full, but o_pred_ready=0 when full, so no push occurs.
- i_flush=1: the next state is pointers=0 and count=0. Any resolve and push in the same cycle are dropped, with no BHT update and no mispredict.
- Dropped (flushed) entries never generate BHT updates.
- Priority: reset > i_flush > mispredict flush > normal push/resolve.

Test Plan:
- Reset, then push 4 entries (pc 0x100/0x104/0x108/0x10C, idx 1..4, all taken=1) -> count 4, o_pred_ready=0. A 5th push is ignored and count stays 4.
- Resolve oldest with taken=1 -> next cycle o_bht_update=1, o_set_index=1, o_branch_taken=1, o_mispredict=0; count 3.
- Resolve entry (pc 0x104, pred taken) with taken=0 -> next cycle o_mispredict=1, o_redirect_pc=0x108, o_set_index=2; count 0 and o_res_ready=0.
- Pred not-taken at pc 0x200, resolve taken with target 0x400 -> o_mispredict=1, o_redirect_pc=0x400. Concurrent push that cycle is dropped, so count is 0.
- Full queue, same-cycle correct resolve plus push attempt -> push blocked (ready=0), count 3. Then same-cycle push+resolve at count 3 -> count stays 3 and pointers wrap correctly over 8 operations.
- i_flush asserted with i_res_valid=1 at count 2 -> no o_bht_update next cycle, count 0. Assert i_rst_n=0 mid-stream -> all outputs 0 and count 0 on the next edge.
